// File: rtl/add_sched_if.sv
// rtl/add_sched_if.sv - Request, operand and result signals of the nibble-serial add scheduler.
// Optional op0/op1 subtract selects exist only when ADD_SCHED_SUB_EN is defined.
interface add_sched_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;

  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ci0, ci1;
`ifdef ADD_SCHED_SUB_EN
  logic         op0, op1;
`endif
  logic [1:0]   gnt;
  logic         busy, done, id;
  logic [W-1:0] s;
  logic         co;

  modport master (
`ifdef ADD_SCHED_SUB_EN
    output op0, op1,
`endif
    output req0, req1, a0, b0, a1, b1, ci0, ci1,
    input  gnt, busy, done, id, s, co
  );

  modport slave (
`ifdef ADD_SCHED_SUB_EN
    input  op0, op1,
`endif
    input  req0, req1, a0, b0, a1, b1, ci0, ci1,
    output gnt, busy, done, id, s, co
  );
endinterface

// File: rtl/add_sched.sv
// rtl/add_sched.sv - Two-requester round-robin adder, one 4-bit slice per cycle, LSB first.
// Define ADD_SCHED_SUB_EN to add per-requester op select (op=1 computes a + ~b + ci).
module add_sched #(
  parameter int NIBBLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  add_sched_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       state;
  logic [W-1:0] a_r, b_r, work;
  logic         cry;
  logic         last;
  logic         own;
  logic [CW-1:0] k;

  logic [W-1:0] b0_eff, b1_eff;
  logic         any_req, winner;
  logic [4:0]   slice;
  logic [W+3:0] shifted;

  // Subtraction is folded into the captured b so the datapath only ever adds.
`ifdef ADD_SCHED_SUB_EN
  assign b0_eff = bus.op0 ? ~bus.b0 : bus.b0;
  assign b1_eff = bus.op1 ? ~bus.b1 : bus.b1;
`else
  assign b0_eff = bus.b0;
  assign b1_eff = bus.b1;
`endif

  always_comb begin
    any_req = bus.req0 | bus.req1;
    winner  = (bus.req0 && bus.req1) ? ~last : bus.req1;
    slice   = {1'b0, a_r[3:0]} + {1'b0, b_r[3:0]} + {4'b0000, cry};
    shifted = {slice[3:0], work};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      work     <= '0;
      cry      <= 1'b0;
      last     <= 1'b1;
      own      <= 1'b0;
      k        <= '0;
      bus.gnt  <= 2'b00;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.id   <= 1'b0;
      bus.s    <= '0;
      bus.co   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          bus.gnt  <= 2'b00;
          if (any_req) begin
            state    <= CALC;
            bus.busy <= 1'b1;
            bus.gnt  <= winner ? 2'b10 : 2'b01;
            last     <= winner;
            own      <= winner;
            a_r      <= winner ? bus.a1  : bus.a0;
            b_r      <= winner ? b1_eff  : b0_eff;
            cry      <= winner ? bus.ci1 : bus.ci0;
            k        <= '0;
          end
        end
        CALC: begin
          bus.gnt <= 2'b00;
          a_r     <= a_r >> 4;
          b_r     <= b_r >> 4;
          cry     <= slice[4];
          work    <= shifted[W+3:4];
          k       <= k + CW'(1);
          // Result is published only once the final nibble lands, so s never shows partial sums.
          if (k == K_LAST) begin
            state    <= DONE;
            bus.done <= 1'b1;
            bus.s    <= shifted[W+3:4];
            bus.co   <= slice[4];
            bus.id   <= own;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add_sched.sv
// tb/tb_add_sched.sv - Randomized self-checking bench for add_sched against an arithmetic model.
// Build with ADD_SCHED_SUB_EN to also exercise the subtract path.
module tb_add_sched;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic rr_last;

  add_sched_if #(.NIBBLES(NIB)) bus ();

  add_sched #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic op);
    logic [W-1:0] bb;
    bb = op ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
  endfunction

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    bus.ci0 = 1'b0; bus.ci1 = 1'b0;
`ifdef ADD_SCHED_SUB_EN
    bus.op0 = 1'b0; bus.op1 = 1'b0;
`endif
  endtask

  // Drives one request (mask selects requesters), scrambles operands after the grant, waits for done.
  task automatic do_txn(input logic [1:0] mask,
                        input logic [W-1:0] x0, input logic [W-1:0] y0, input logic c0, input logic o0,
                        input logic [W-1:0] x1, input logic [W-1:0] y1, input logic c1, input logic o1,
                        output logic [1:0] g, output int cyc, output logic [W-1:0] rs,
                        output logic rco, output logic rid, output logic schg, output logic to);
    logic [W-1:0] s_hold;
    int n;
    g = 2'b00; cyc = 0; rs = '0; rco = 1'b0; rid = 1'b0; schg = 1'b0; to = 1'b0;
    @(negedge clk);
    bus.a0 = x0; bus.b0 = y0; bus.ci0 = c0;
    bus.a1 = x1; bus.b1 = y1; bus.ci1 = c1;
`ifdef ADD_SCHED_SUB_EN
    bus.op0 = o0; bus.op1 = o1;
`else
    if (o0 | o1) $display("[TB] note: op ignored without subtract support");
`endif
    bus.req0 = mask[0]; bus.req1 = mask[1];
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == 2'b00 && n < 50);
    if (bus.gnt == 2'b00) begin
      to = 1'b1;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      return;
    end
    g = bus.gnt;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    s_hold = bus.s;
    bus.a0 = W'($urandom); bus.b0 = W'($urandom); bus.ci0 = 1'($urandom);
    bus.a1 = W'($urandom); bus.b1 = W'($urandom); bus.ci1 = 1'($urandom);
`ifdef ADD_SCHED_SUB_EN
    bus.op0 = 1'($urandom); bus.op1 = 1'($urandom);
`endif
    n = 0;
    while (!bus.done && n < 50) begin
      @(negedge clk);
      n++;
      if (!bus.done && bus.s !== s_hold) schg = 1'b1;
    end
    if (!bus.done) to = 1'b1;
    cyc = n; rs = bus.s; rco = bus.co; rid = bus.id;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.gnt !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.id !== 1'b0 ||
        bus.s !== '0 || bus.co !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b busy=%b done=%b id=%b s=%h co=%b, want all zero",
               bus.gnt, bus.busy, bus.done, bus.id, bus.s, bus.co);
    end
    rst_n = 1'b1;
    rr_last = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: gnt=%b busy=%b, want 00/0 with no request", bus.gnt, bus.busy);
    end
  endtask

  task automatic test_single_add();
    logic [1:0] g; int cyc; logic [W-1:0] rs; logic rco, rid, schg, to;
    do_txn(2'b01, 16'h1234, 16'h4321, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, g, cyc, rs, rco, rid, schg, to);
    rr_last = 1'b0;
    n_tests++;
    if (to !== 1'b0 || g !== 2'b01 || cyc != NIB) begin
      n_fail++;
      $display("FAIL single_handshake: to=%b gnt=%b latency=%0d, want 0/01/%0d", to, g, cyc, NIB);
    end
    n_tests++;
    if (rs !== 16'h5555 || rco !== 1'b0 || rid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_result: s=%h co=%b id=%b, want 5555/0/0", rs, rco, rid);
    end
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b0 || bus.s !== 16'h5555) begin
      n_fail++;
      $display("FAIL single_pulse_hold: done=%b s=%h, want 0/5555", bus.done, bus.s);
    end
  endtask

  task automatic test_carry_chain();
    logic [1:0] g; int cyc; logic [W-1:0] rs; logic rco, rid, schg, to;
    do_txn(2'b10, '0, '0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, g, cyc, rs, rco, rid, schg, to);
    rr_last = 1'b1;
    n_tests++;
    if (to !== 1'b0 || g !== 2'b10 || rs !== 16'h0000 || rco !== 1'b1 || rid !== 1'b1) begin
      n_fail++;
      $display("FAIL carry_wrap: to=%b gnt=%b s=%h co=%b id=%b, want 0/10/0000/1/1", to, g, rs, rco, rid);
    end
    do_txn(2'b10, '0, '0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, g, cyc, rs, rco, rid, schg, to);
    n_tests++;
    if (to !== 1'b0 || rs !== 16'h0001 || rco !== 1'b0 || rid !== 1'b1) begin
      n_fail++;
      $display("FAIL carry_in: to=%b s=%h co=%b id=%b, want 0/0001/0/1", to, rs, rco, rid);
    end
  endtask

  task automatic test_stability();
    logic [1:0] g; int cyc; logic [W-1:0] rs; logic rco, rid, schg, to;
    logic [W:0] exp;
    exp = model_sum(16'hABCD, 16'h1357, 1'b1, 1'b0);
    do_txn(2'b01, 16'hABCD, 16'h1357, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, g, cyc, rs, rco, rid, schg, to);
    rr_last = 1'b0;
    n_tests++;
    if (to !== 1'b0 || schg !== 1'b0 || {rco, rs} !== exp) begin
      n_fail++;
      $display("FAIL stability: to=%b s_moved=%b co:s=%b:%h, want 0/0/%b:%h", to, schg, rco, rs, exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_tie();
    logic [1:0] gq[$];
    logic       idq[$];
    logic [W:0] sq[$];
    int         gcyc[$];
    int         extra;
    idle_inputs();
    rst_n = 1'b0;
    bus.a0 = 16'h1111; bus.b0 = 16'h2222; bus.ci0 = 1'b0;
    bus.a1 = 16'h0F0F; bus.b1 = 16'h0101; bus.ci1 = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100 && idq.size() < 3; i++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) begin
        gq.push_back(bus.gnt);
        gcyc.push_back(i);
      end
      if (bus.done) begin
        idq.push_back(bus.id);
        sq.push_back({bus.co, bus.s});
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) extra++;
    end
    rr_last = 1'b0;
    n_tests++;
    if (gq.size() != 3 || idq.size() != 3 || extra != 0) begin
      n_fail++;
      $display("FAIL tie_counts: grants=%0d dones=%0d extra=%0d, want 3/3/0", gq.size(), idq.size(), extra);
    end else begin
      n_tests++;
      if (gq[0] !== 2'b01 || gq[1] !== 2'b10 || gq[2] !== 2'b01) begin
        n_fail++;
        $display("FAIL tie_order: grants %b %b %b, want 01 10 01", gq[0], gq[1], gq[2]);
      end
      n_tests++;
      if (idq[0] !== 1'b0 || idq[1] !== 1'b1 || idq[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL tie_ids: ids %b %b %b, want 0 1 0", idq[0], idq[1], idq[2]);
      end
      n_tests++;
      if (sq[0] !== model_sum(16'h1111, 16'h2222, 1'b0, 1'b0) ||
          sq[1] !== model_sum(16'h0F0F, 16'h0101, 1'b1, 1'b0)) begin
        n_fail++;
        $display("FAIL tie_sums: got %h %h, want %h %h", sq[0], sq[1],
                 model_sum(16'h1111, 16'h2222, 1'b0, 1'b0), model_sum(16'h0F0F, 16'h0101, 1'b1, 1'b0));
      end
      n_tests++;
      if (gcyc[1] - gcyc[0] != NIB + 2 || gcyc[2] - gcyc[1] != NIB + 2) begin
        n_fail++;
        $display("FAIL tie_spacing: gaps %0d %0d, want %0d", gcyc[1] - gcyc[0], gcyc[2] - gcyc[1], NIB + 2);
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [1:0] g; int cyc; logic [W-1:0] rs; logic rco, rid, schg, to;
    int dones, n;
    do_txn(2'b01, 16'h0101, 16'h0101, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, g, cyc, rs, rco, rid, schg, to);
    @(negedge clk);
    bus.a0 = 16'h2000; bus.b0 = 16'h0030; bus.ci0 = 1'b1;
    bus.req0 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == 2'b00 && n < 20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.s !== '0 || bus.done !== 1'b0 || bus.gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_calc_async: busy=%b s=%h done=%b gnt=%b, want 0/0000/0/00",
               bus.busy, bus.s, bus.done, bus.gnt);
    end
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    rst_n = 1'b1;
    rr_last = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.gnt !== 2'b01 || dones != 0) begin
      n_fail++;
      $display("FAIL reset_resume: gnt=%b dones_in_reset=%0d, want 01/0", bus.gnt, dones);
    end
    bus.req0 = 1'b0;
    rr_last = 1'b0;
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (bus.done !== 1'b1 || {bus.co, bus.s} !== model_sum(16'h2000, 16'h0030, 1'b1, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_resume_result: done=%b s=%h, want 1/2031", bus.done, bus.s);
    end
  endtask

  task automatic test_drop();
    int grants, dones, n;
    idle_inputs();
    @(negedge clk);
    bus.req1 = 1'b1; bus.a1 = 16'h0042; bus.b1 = 16'h0001;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == 2'b00 && n < 20);
    bus.req1 = 1'b0;
    rr_last = 1'b1;
    @(negedge clk);
    bus.req0 = 1'b1;
    @(negedge clk);
    bus.req0 = 1'b0;
    grants = 0; dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) grants++;
      if (bus.done) dones++;
    end
    n_tests++;
    if (grants != 0 || dones != 1 || bus.s !== 16'h0043 || bus.id !== 1'b1) begin
      n_fail++;
      $display("FAIL dropped_request: grants=%0d dones=%0d s=%h id=%b, want 0/1/0043/1",
               grants, dones, bus.s, bus.id);
    end
  endtask

  task automatic test_random();
    logic [1:0] g; int cyc; logic [W-1:0] rs; logic rco, rid, schg, to;
    logic [1:0] mask;
    logic [W-1:0] x0, y0, x1, y1;
    logic c0, c1, o0, o1, win, wo;
    logic [W:0] exp;
    for (int t = 0; t < 40; t++) begin
      mask = 2'($urandom_range(1, 3));
      x0 = W'($urandom); y0 = W'($urandom); c0 = 1'($urandom);
      x1 = W'($urandom); y1 = W'($urandom); c1 = 1'($urandom);
      if (t % 8 == 0) begin x0 = '1; y0 = '0; c0 = 1'b1; end
`ifdef ADD_SCHED_SUB_EN
      o0 = 1'($urandom); o1 = 1'($urandom);
`else
      o0 = 1'b0; o1 = 1'b0;
`endif
      win = (mask == 2'b11) ? ~rr_last : mask[1];
      wo  = win ? o1 : o0;
      exp = win ? model_sum(x1, y1, c1, wo) : model_sum(x0, y0, c0, wo);
      do_txn(mask, x0, y0, c0, o0, x1, y1, c1, o1, g, cyc, rs, rco, rid, schg, to);
      rr_last = win;
      n_tests++;
      if (to !== 1'b0 || g !== (win ? 2'b10 : 2'b01) || cyc != NIB || rid !== win) begin
        n_fail++;
        $display("FAIL random_grant[%0d]: to=%b gnt=%b lat=%0d id=%b, want 0/%b/%0d/%b",
                 t, to, g, cyc, rid, win ? 2'b10 : 2'b01, NIB, win);
      end
      n_tests++;
      if ({rco, rs} !== exp || schg !== 1'b0) begin
        n_fail++;
        $display("FAIL random_sum[%0d]: co:s=%b:%h s_moved=%b, want %b:%h/0",
                 t, rco, rs, schg, exp[W], exp[W-1:0]);
      end
    end
  endtask

`ifdef ADD_SCHED_SUB_EN
  task automatic test_sub();
    logic [1:0] g; int cyc; logic [W-1:0] rs; logic rco, rid, schg, to;
    do_txn(2'b01, 16'h0005, 16'h0007, 1'b1, 1'b1, '0, '0, 1'b0, 1'b0, g, cyc, rs, rco, rid, schg, to);
    rr_last = 1'b0;
    n_tests++;
    if (to !== 1'b0 || rs !== 16'hFFFE || rco !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow: s=%h co=%b, want FFFE/0", rs, rco);
    end
    do_txn(2'b01, 16'h0007, 16'h0005, 1'b1, 1'b1, '0, '0, 1'b0, 1'b0, g, cyc, rs, rco, rid, schg, to);
    n_tests++;
    if (to !== 1'b0 || rs !== 16'h0002 || rco !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_noborrow: s=%h co=%b, want 0002/1", rs, rco);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rr_last = 1'b1;
    rst_n   = 1'b0;
    idle_inputs();
    test_reset();
    test_single_add();
    test_carry_chain();
    test_stability();
    test_tie();
    test_reset_mid_calc();
    test_drop();
`ifdef ADD_SCHED_SUB_EN
    test_sub();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/add_sched.md
ADD_SCHED -- requirements
Module: add_sched

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 Clock/reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0, req1  input  1 each  transaction request from requester 0/1, held high until its grant.
REQ-006 a0, b0, a1, b1  input  W each  operands of requester 0/1.
REQ-007 ci0, ci1  input  1 each  carry-in of requester 0/1.
REQ-008 gnt  output  2  one-hot grant pulse; bit n acknowledges requester n.
REQ-009 busy  output  1  high while a transaction is in CALC or DONE.
REQ-010 done  output  1  one-cycle pulse, result valid.
REQ-011 id  output  1  owner of the current or last result (0 or 1).
REQ-012 s  output  W  sum of the last completed transaction.
REQ-013 co  output  1  carry-out of the last completed transaction.

Function
REQ-014 The block SHALL compute one W-bit addition over one shared 4-bit add slice, one nibble per cycle, LSB nibble first, using a registered inter-nibble carry.
REQ-015 States SHALL be IDLE, CALC, DONE; IDLE->CALC on any sampled request, CALC->DONE after NIBBLES cycles, DONE->IDLE unconditionally after one cycle.
REQ-016 Requests SHALL be sampled only in IDLE; requests present in CALC or DONE wait with no effect.
REQ-017 On the IDLE->CALC edge the block SHALL capture the winner's a, b, ci and id, and assert gnt[winner] for exactly the following cycle.
REQ-018 Arbitration SHALL be round-robin: one requester active -> it wins; both active -> the one not granted last wins.
REQ-019 CALC cycle k (k = 0..NIBBLES-1) SHALL write s nibble k = a[k]+b[k]+carry and update the carry; carry for k=0 is the captured ci.
REQ-020 done SHALL go high NIBBLES cycles after the gnt cycle, for exactly one cycle, with s, co and id valid.
REQ-021 s, co and id SHALL hold their values from done until the next done; intermediate nibbles SHALL NOT be visible on s before done (separate working register).
REQ-022 Latency: request sampled at edge E0 -> done high during the cycle after edge E(NIBBLES); earliest next capture is edge E(NIBBLES+2).
REQ-023 Operand changes after the grant edge SHALL NOT affect the result; a request dropped before its grant SHALL produce no transaction.
REQ-024 co SHALL equal bit W of the full-width sum a+b+ci (wrap-around into s, e.g. FFFF+0001+0 -> s=0000, co=1 for W=16).

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, gnt=00, busy=0, done=0, id=0, s=0, co=0, carry=0.
REQ-026 Reset SHALL set the round-robin last-granted pointer to 1 so requester 0 wins the first tie.
REQ-027 Reset during CALC or DONE SHALL abort the transaction with no done pulse; operation resumes from IDLE on the first edge after release.

Configuration
REQ-028 Macro ADD_SCHED_SUB_EN, when defined, SHALL add inputs op0, op1 (1 bit each); op=1 computes a + ~b + ci (ci=1 gives a-b, co=1 means no borrow); op is captured with the operands.
REQ-029 Without ADD_SCHED_SUB_EN the op ports SHALL be absent and every transaction SHALL be an addition.

Verification
REQ-030 Single add: req0, a0=1234, b0=4321 (hex), ci0=0 -> gnt=01 one cycle, done 4 cycles later, s=5555, co=0, id=0.
REQ-031 Carry chain: req1, a1=FFFF, b1=0001, ci1=0 -> s=0000, co=1, id=1; ci1=1 with a1=b1=0000 -> s=0001, co=0.
REQ-032 Tie: req0 and req1 both held from reset -> grants 01, 10, 01 in order; three done pulses with id 0, 1, 0.
REQ-033 Stability: change a0 to 0000 the cycle after gnt -> result uses the captured value; s unchanged until done.
REQ-034 Reset mid-CALC: rst_n low in the 2nd CALC cycle -> no done, s=0000, busy=0; pending req0 is granted on the first edge after release.
REQ-035 With ADD_SCHED_SUB_EN: op0=1, a0=0005, b0=0007, ci0=1 -> s=FFFE, co=0; a0=0007, b0=0005 -> s=0002, co=1.
